// File: rtl/matrix_mult_param.sv
// Signed NxN matrix multiplier C = A x B built around a single sequential MAC unit.
// Start/busy/done handshake; results wrap or saturate to DW bits with a sticky overflow flag.
module matrix_mult_param #(
  parameter int N     = 3,
  parameter int DW    = 8,
  parameter int ACC_W = 2*DW+$clog2(N),
  parameter int SAT   = 0
) (
  input  logic              Clock,
  input  logic              reset,
  input  logic              start,
  input  logic [N*N*DW-1:0] A,
  input  logic [N*N*DW-1:0] B,
  output logic [N*N*DW-1:0] C,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N-1);
  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_r;
  state_t state_next_s;

  logic signed [DW-1:0]    a_q_r [N][N];
  logic signed [DW-1:0]    b_q_r [N][N];
  logic signed [DW-1:0]    res_r [N][N];
  logic signed [ACC_W-1:0] acc_r;
  logic [IW-1:0]           i_r;
  logic [IW-1:0]           j_r;
  logic [IW-1:0]           k_r;
  logic                    ovf_int_r;

  logic signed [DW-1:0]    a_el_s;
  logic signed [DW-1:0]    b_el_s;
  logic signed [ACC_W-1:0] a_ext_s;
  logic signed [ACC_W-1:0] b_ext_s;
  logic signed [ACC_W-1:0] prod_s;
  logic signed [ACC_W-1:0] sum_s;
  logic [DW-1:0]           red_s;
  logic                    red_ovf_s;
  logic                    last_s;

  // Wrap keeps the low DW bits; saturate clamps to the signed DW range first.
  function automatic logic [DW-1:0] reduce_f(input logic signed [ACC_W-1:0] v);
    logic [DW-1:0] r;
    if ((SAT != 0) && (v > MAX_V)) begin
      r = MAX_V[DW-1:0];
    end else if ((SAT != 0) && (v < MIN_V)) begin
      r = MIN_V[DW-1:0];
    end else begin
      r = v[DW-1:0];
    end
    return r;
  endfunction

  // MAC datapath: current product, running sum and its DW-bit reduction
  always_comb begin
    a_el_s    = a_q_r[i_r][k_r];
    b_el_s    = b_q_r[k_r][j_r];
    a_ext_s   = {{(ACC_W-DW){a_el_s[DW-1]}}, a_el_s};
    b_ext_s   = {{(ACC_W-DW){b_el_s[DW-1]}}, b_el_s};
    prod_s    = a_ext_s * b_ext_s;
    sum_s     = acc_r + prod_s;
    red_s     = reduce_f(sum_s);
    red_ovf_s = ({{(ACC_W-DW){red_s[DW-1]}}, red_s} != sum_s);
    last_s    = (i_r == LAST) && (j_r == LAST) && (k_r == LAST);
  end

  // State register
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_MAC;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_MAC: begin
        if (last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_MAC;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Operand capture, index walk (k innermost, then j, then i) and accumulation
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_q_r[r][c] <= '0;
          b_q_r[r][c] <= '0;
          res_r[r][c] <= '0;
        end
      end
      acc_r     <= '0;
      i_r       <= '0;
      j_r       <= '0;
      k_r       <= '0;
      ovf_int_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            for (int r = 0; r < N; r++) begin
              for (int c = 0; c < N; c++) begin
                a_q_r[r][c] <= A[(r*N+c)*DW +: DW];
                b_q_r[r][c] <= B[(r*N+c)*DW +: DW];
              end
            end
            acc_r     <= '0;
            i_r       <= '0;
            j_r       <= '0;
            k_r       <= '0;
            ovf_int_r <= 1'b0;
          end
        end
        ST_MAC: begin
          if (k_r == LAST) begin
            res_r[i_r][j_r] <= red_s;
            acc_r           <= '0;
            k_r             <= '0;
            if (red_ovf_s) begin
              ovf_int_r <= 1'b1;
            end
            if (j_r == LAST) begin
              j_r <= '0;
              i_r <= (i_r == LAST) ? '0 : i_r + IW'(1);
            end else begin
              j_r <= j_r + IW'(1);
            end
          end else begin
            acc_r <= sum_s;
            k_r   <= k_r + IW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output registers: C and ovf change only on the done edge
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      C    <= '0;
      ovf  <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            busy <= 1'b1;
          end
        end
        ST_DONE: begin
          for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
              C[(r*N+c)*DW +: DW] <= res_r[r][c];
            end
          end
          ovf  <= ovf_int_r;
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_mult_param.sv
// Scoreboard bench: three matrix_mult_param instances (N=3 wrap, N=3 saturate, N=2 wrap),
// directed vectors with hand-computed results, checked by per-instance monitors on done.
module tb_matrix_mult_param;

  logic        Clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic [71:0] A = 72'd0;
  logic [71:0] B = 72'd0;
  logic [31:0] A2 = 32'd0;
  logic [31:0] B2 = 32'd0;
  logic [71:0] C0, C1;
  logic [31:0] C2;
  logic        busy0, done0, ovf0;
  logic        busy1, done1, ovf1;
  logic        busy2, done2, ovf2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_cnt0 = 0;

  typedef struct {
    logic [71:0] c;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  matrix_mult_param #(.N(3), .DW(8), .SAT(0)) u0 (
    .Clock(Clock), .reset(reset), .start(start), .A(A), .B(B),
    .C(C0), .busy(busy0), .done(done0), .ovf(ovf0)
  );
  matrix_mult_param #(.N(3), .DW(8), .SAT(1)) u1 (
    .Clock(Clock), .reset(reset), .start(start), .A(A), .B(B),
    .C(C1), .busy(busy1), .done(done1), .ovf(ovf1)
  );
  matrix_mult_param #(.N(2), .DW(8), .SAT(0)) u2 (
    .Clock(Clock), .reset(reset), .start(start2), .A(A2), .B(B2),
    .C(C2), .busy(busy2), .done(done2), .ovf(ovf2)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  function automatic logic [71:0] pk3(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
    return {8'(e8), 8'(e7), 8'(e6), 8'(e5), 8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  function automatic logic [31:0] pk2(input int e0, e1, e2, e3);
    return {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic no_pending(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got done=1, expected no pending result", nm);
  endtask

  always @(negedge Clock) begin : mon0
    exp_t e;
    if (reset) begin
      busy_cnt0 = 0;
    end else begin
      if (busy0) busy_cnt0++;
      if (done0) begin
        if (q0.size() == 0) begin
          no_pending("d0_spurious_done");
        end else begin
          e = q0.pop_front();
          chk("d0_C", C0, e.c);
          chk("d0_ovf", 72'(ovf0), 72'(e.ovf));
          chk("d0_latency", 72'(cyc - e.acc), 72'd28);
          chk("d0_busy_cycles", 72'(busy_cnt0), 72'd28);
        end
        busy_cnt0 = 0;
      end
    end
  end

  always @(negedge Clock) begin : mon1
    exp_t e;
    if (!reset && done1) begin
      if (q1.size() == 0) begin
        no_pending("d1_spurious_done");
      end else begin
        e = q1.pop_front();
        chk("d1_C", C1, e.c);
        chk("d1_ovf", 72'(ovf1), 72'(e.ovf));
        chk("d1_latency", 72'(cyc - e.acc), 72'd28);
      end
    end
  end

  always @(negedge Clock) begin : mon2
    exp_t e;
    if (!reset && done2) begin
      if (q2.size() == 0) begin
        no_pending("d2_spurious_done");
      end else begin
        e = q2.pop_front();
        chk("d2_C", 72'(C2), e.c);
        chk("d2_ovf", 72'(ovf2), 72'(e.ovf));
        chk("d2_latency", 72'(cyc - e.acc), 72'd9);
      end
    end
  end

  // Drive one N=3 operation on the shared u0/u1 inputs; operands are scrambled after acceptance.
  task automatic go3(input logic [71:0] a, b, e0, input logic o0,
                     input logic [71:0] e1, input logic o1, input bit push);
    @(negedge Clock);
    A = a; B = b; start = 1'b1;
    if (push) begin
      q0.push_back('{e0, o0, cyc + 1});
      q1.push_back('{e1, o1, cyc + 1});
    end
    @(negedge Clock);
    start = 1'b0; A = ~a; B = ~b;
  endtask

  task automatic go2(input logic [31:0] a, b, e, input logic o);
    @(negedge Clock);
    A2 = a; B2 = b; start2 = 1'b1;
    q2.push_back('{72'(e), o, cyc + 1});
    @(negedge Clock);
    start2 = 1'b0; A2 = ~a; B2 = ~b;
  endtask

  task automatic drain();
    int t = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && t < 300) begin
      @(negedge Clock);
      t++;
    end
    checks++;
    if (t >= 300) begin
      errors++;
      $display("FAIL drain_timeout: got %0d results pending, expected 0",
               q0.size() + q1.size() + q2.size());
      q0.delete(); q1.delete(); q2.delete();
    end
    repeat (3) @(negedge Clock);
  endtask

  initial begin
    logic [71:0] ident, neg_ident, b19, a19, ones, all16, all7f, allm128;
    ident     = pk3(1, 0, 0, 0, 1, 0, 0, 0, 1);
    neg_ident = pk3(-1, 0, 0, 0, -1, 0, 0, 0, -1);
    b19       = pk3(1, 2, 3, 4, 5, 6, 7, 8, 9);
    a19       = b19;
    ones      = {9{8'h01}};
    all16     = {9{8'h10}};
    all7f     = {9{8'h7F}};
    allm128   = {9{8'h80}};

    @(negedge Clock);
    chk("rst_d0_C", C0, 72'd0);
    chk("rst_d0_busy", 72'(busy0), 72'd0);
    chk("rst_d0_done", 72'(done0), 72'd0);
    chk("rst_d0_ovf", 72'(ovf0), 72'd0);
    chk("rst_d1_C", C1, 72'd0);
    chk("rst_d2_C", 72'(C2), 72'd0);
    reset = 1'b0;

    go3(ident, b19, b19, 1'b0, b19, 1'b0, 1'b1);
    drain();
    go3(all16, all16, 72'd0, 1'b1, all7f, 1'b1, 1'b1);
    drain();
    go3(neg_ident, b19, pk3(-1, -2, -3, -4, -5, -6, -7, -8, -9), 1'b0,
        pk3(-1, -2, -3, -4, -5, -6, -7, -8, -9), 1'b0, 1'b1);
    drain();
    go3(allm128, allm128, 72'd0, 1'b1, all7f, 1'b1, 1'b1);
    drain();

    // Abort mid-operation: outputs clear immediately, next operation is clean.
    go3(all16, all16, 72'd0, 1'b0, 72'd0, 1'b0, 1'b0);
    repeat (8) @(negedge Clock);
    reset = 1'b1;
    #1;
    chk("abort_d0_busy", 72'(busy0), 72'd0);
    chk("abort_d1_C", C1, 72'd0);
    chk("abort_d1_ovf", 72'(ovf1), 72'd0);
    chk("abort_d1_done", 72'(done1), 72'd0);
    @(negedge Clock);
    reset = 1'b0;
    go3(ident, b19, b19, 1'b0, b19, 1'b0, 1'b1);
    drain();

    // A start pulse while busy is ignored.
    go3(neg_ident, b19, pk3(-1, -2, -3, -4, -5, -6, -7, -8, -9), 1'b0,
        pk3(-1, -2, -3, -4, -5, -6, -7, -8, -9), 1'b0, 1'b1);
    repeat (3) @(negedge Clock);
    start = 1'b1;
    @(negedge Clock);
    start = 1'b0;
    drain();

    // Start held high re-arms on the edge after done.
    @(negedge Clock);
    A = a19; B = ones; start = 1'b1;
    q0.push_back('{pk3(6, 6, 6, 15, 15, 15, 24, 24, 24), 1'b0, cyc + 1});
    q1.push_back('{pk3(6, 6, 6, 15, 15, 15, 24, 24, 24), 1'b0, cyc + 1});
    q0.push_back('{pk3(6, 6, 6, 15, 15, 15, 24, 24, 24), 1'b0, cyc + 30});
    q1.push_back('{pk3(6, 6, 6, 15, 15, 15, 24, 24, 24), 1'b0, cyc + 30});
    repeat (30) @(negedge Clock);
    start = 1'b0;
    drain();

    go2(pk2(1, 2, 3, 4), pk2(5, 6, 7, 8), pk2(19, 22, 43, 50), 1'b0);
    drain();
    go2(pk2(-1, 2, 3, -4), pk2(5, 6, 7, 8), pk2(9, 10, -13, -14), 1'b0);
    drain();
    go2({4{8'h7F}}, {4{8'h7F}}, {4{8'h02}}, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
